contador_param: RTL

Parametrised successor to the team's 4-bit mode counter. It is a synchronous up/down/step counter with parallel load, generic in width and step size. Wrap or saturate behaviour is chosen at elaboration time, and the wrap and load indications are registered. It sits in the same datapath slot as the fixed 4-bit counter and can be cascaded through `rco`.

---
 rtl/contador_pkg.sv | 18 +
 rtl/contador_next.sv | 67 ++++++
 rtl/contador_param.sv | 64 ++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared mode encodings and helpers for the
// parametrised up/down/step counter.
package contador_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // All-ones value of a w-bit counter, valid up to 64 bits
  function automatic logic [63:0] max_val(
    input int unsigned w
  );
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/contador_next.sv
// Next-state logic for contador_param: one WIDTH+1
// adder/subtractor plus wrap/clamp selection.
module contador_next
  import contador_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STEP     = 3,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [1:0]       mode_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] next_q_o,
  output logic             next_rco_o,
  output logic             next_load_o
);

  localparam logic [WIDTH-1:0] MAXV =
    WIDTH'(max_val(WIDTH));
  localparam logic [WIDTH:0] STEPW =
    (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONEW =
    (WIDTH+1)'(1);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;
  logic           sub;
  logic           carry;
  logic           is_load;

  always_comb begin
    is_load = (mode_i == MODE_LOAD);
    sub     = (mode_i == MODE_DOWN);
    addend  = (mode_i == MODE_STEP) ? STEPW : ONEW;
    // Top bit is carry when adding, borrow when subtracting
    sum     = sub ? ({1'b0, q_i} - addend)
                  : ({1'b0, q_i} + addend);
    carry   = sum[WIDTH];
  end

  always_comb begin
    next_q_o    = q_i;
    next_rco_o  = 1'b0;
    next_load_o = 1'b0;
    priority case (1'b1)
      is_load: begin
        next_q_o    = d_i;
        next_load_o = 1'b1;
      end
      !enable_i: begin
        next_q_o = q_i;
      end
      carry: begin
        next_rco_o = 1'b1;
        if (SATURATE != 0)
          next_q_o = sub ? '0 : MAXV;
        else
          next_q_o = sum[WIDTH-1:0];
      end
      default: begin
        next_q_o = sum[WIDTH-1:0];
      end
    endcase
  end

endmodule

// File: rtl/contador_param.sv
// Parametrised up/down/step counter with load;
// Q, rco and load are all registered.
module contador_param
  import contador_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STEP     = 3,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             load
);

  if (WIDTH < 2 || STEP < 1 ||
      (WIDTH < 32 &&
       longint'(STEP) >= (longint'(1) << WIDTH)))
  begin : g_bad_param
    $fatal(1, "contador_param: illegal WIDTH/STEP");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             rco_q;
  logic             rco_d;
  logic             load_q;
  logic             load_d;

  contador_next #(
    .WIDTH    (WIDTH),
    .STEP     (STEP),
    .SATURATE (SATURATE)
  ) u_next (
    .q_i         (q_q),
    .mode_i      (mode),
    .enable_i    (enable),
    .d_i         (D),
    .next_q_o    (q_d),
    .next_rco_o  (rco_d),
    .next_load_o (load_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      rco_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rco_q  <= rco_d;
      load_q <= load_d;
    end
  end

  assign Q    = q_q;
  assign rco  = rco_q;
  assign load = load_q;

endmodule
